// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the receiver and the future transmitter.
package uart_pkg;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 868;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
endpackage

// File: rtl/uart_rx_sync2.sv
// sync2: two-flop synchroniser for an asynchronous input, reset value selectable.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk)
        if (!reset) {q, meta} <= {2{RESET_VAL}};
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with one-cycle result strobes; define UART_RX_PARITY_EN for 8E1.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] d_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    uart_state_e state, state_n;
    logic [CW-1:0] ctr, ctr_n;
    logic [2:0] idx, idx_n;
    logic [UART_DATA_BITS-1:0] data_r, data_n;
    logic [7:0] d_out_n;
    logic perr_r, perr_n, done_n, ferr_n, pe_n, rx_s, bit_end;
    sync2 #(.RESET_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d(rx), .q(rx_s));
    assign bit_end = ctr == CW'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            ctr        <= '0;
            idx        <= '0;
            data_r     <= '0;
            perr_r     <= 1'b0;
            d_out      <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_n;
            ctr        <= ctr_n;
            idx        <= idx_n;
            data_r     <= data_n;
            perr_r     <= perr_n;
            d_out      <= d_out_n;
            rx_done    <= done_n;
            frame_err  <= ferr_n;
            parity_err <= pe_n;
        end
    end
    always_comb begin
        state_n = state;
        ctr_n   = ctr + 1'b1;
        idx_n   = idx;
        data_n  = data_r;
        perr_n  = perr_r;
        d_out_n = d_out;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
        pe_n    = 1'b0;
        case (state)
            IDLE: begin
                ctr_n = '0;
                if (!rx_s) state_n = START;
            end
            START: if (ctr == CW'(HALF - 1)) begin
                ctr_n   = '0;
                idx_n   = '0;
                perr_n  = 1'b0;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (bit_end) begin
                ctr_n       = '0;
                data_n[idx] = rx_s;
                idx_n       = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (idx == 3'(UART_DATA_BITS - 1)) state_n = PARITY;
`else
                if (idx == 3'(UART_DATA_BITS - 1)) state_n = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (bit_end) begin
                ctr_n   = '0;
                perr_n  = rx_s != ^data_r;
                state_n = STOP;
            end
`endif
            // Leave at the stop-bit sample point so a back-to-back start edge is not missed
            STOP: if (bit_end) begin
                ctr_n   = '0;
                state_n = IDLE;
                ferr_n  = !rx_s;
                pe_n    = perr_r;
                done_n  = rx_s && !perr_r;
                d_out_n = done_n ? data_r : d_out;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver feeding the AES communication path: it synchronises the external `rx` line, recovers 8-bit frames (start, 8 data LSB-first, optional parity, 1 stop), and presents each good byte on `d_out` with a single-cycle `rx_done` strobe. It sits directly upstream of the 128-bit byte-accumulating shift stage, which consumes `d_out`/`rx_done` one byte per pulse.

## Interface
- `CLKS_PER_BIT`, 868, clk cycles per bit (100 MHz / 115200); must be ≥ 4
- `clk`  input  1  system clock
- `reset`  input  1  reset, synchronous, active-low; clock clk
- `rx`  input  1  asynchronous serial line, idle high
- `d_out`  output  8  last correctly received byte
- `rx_done`  output  1  one-cycle strobe, `d_out` valid
- `frame_err`  output  1  one-cycle strobe, stop bit sampled low
- `parity_err`  output  1  one-cycle strobe, parity mismatch (constant 0 when parity compiled out)

## Operation
- `rx` passes through a 2-flop synchroniser; its output `rx_s` drives all logic. Synchroniser flops reset to 1.
- `HALF = CLKS_PER_BIT/2` (integer division). Bit counter `ctr` is `$clog2(CLKS_PER_BIT)` bits; bit index is 3 bits.
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: `rx_s==0` → START, `ctr←0`.
- START: at `ctr==HALF-1` sample `rx_s`; 0 → DATA, `ctr←0`, index←0; 1 → IDLE (glitch reject, no strobe).
- DATA: at `ctr==CLKS_PER_BIT-1` shift `rx_s` into the byte register at bit[index] (LSB first), `ctr←0`; after index 7 → PARITY or STOP.
- PARITY: at `ctr==CLKS_PER_BIT-1` compare `rx_s` with even parity (XOR of 8 data bits); store the result → STOP.
- STOP: at `ctr==CLKS_PER_BIT-1` sample `rx_s` and return to IDLE in the same transition. No wait for the end of the stop bit, so back-to-back frames are accepted.
- Result, registered on the cycle after the stop sample:
  - stop high and parity ok: `d_out←byte`, `rx_done=1`.
  - stop low: `frame_err=1`, `rx_done=0`, `d_out` unchanged.
  - parity bad: `parity_err=1`, `rx_done=0`, `d_out` unchanged.
  - Both errors pulse together if both occur.
- `d_out` holds its value until the next good frame and is stable whenever `rx_done` is high.

## Timing
- Reset values: `d_out=0x00`, `rx_done=0`, `frame_err=0`, `parity_err=0`, state IDLE, `ctr=0`.
- Reset mid-frame aborts immediately with no strobe; the next frame is received normally.
- Let E be the first cycle `rx_s` reads 0. The stop sample occurs at E+HALF+9·CLKS_PER_BIT (+CLKS_PER_BIT with parity), give or take one cycle of counter alignment. Strobes assert one cycle after the stop sample.
- Strobes are exactly one cycle wide. At most one `rx_done` per frame. The downstream stage relies on this.
- Pin-to-`rx_s` latency is 2 cycles. Total frame jitter tolerance is about ±HALF cycles accumulated over 10 bits.
- A low level already present on `rx_s` when returning to IDLE starts a new frame on the next cycle.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state present; frame is 11 bits (8E1); `parity_err` active.
- Undefined: 8N1 only; PARITY state absent; `parity_err` tied 0; frame timing drops one bit period.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - `UART_DATA_BITS=8`
  - default `UART_CLKS_PER_BIT=868`
  - the package is shared with the future transmitter.
- One sub-module: `sync2`, a 2-flop synchroniser with parameterised reset value, reusable for other async inputs.

## Test plan
- CLKS_PER_BIT=16, send 0xA5 8N1 → one `rx_done` pulse, `d_out=0xA5`, no error strobes.
- 16 back-to-back frames 0x00..0x0F, no idle gap → 16 `rx_done` pulses in order; downstream 128-bit block = 0x000102030405060708090A0B0C0D0E0F.
- `rx` low for 4 cycles (< HALF=8) then high → returns to IDLE, no strobe of any kind.
- Frame 0x3C with stop bit low → `frame_err` pulse, no `rx_done`, `d_out` keeps previous 0xA5.
- `reset` low during data bit 4 of 0xFF → all outputs 0 next cycle; subsequent 0x5A received, `d_out=0x5A`.
- With `UART_RX_PARITY_EN`:
  - 0x81 with parity bit 1 → `parity_err` pulse, no `rx_done`.
  - 0x81 with parity bit 0 → `rx_done`, `d_out=0x81`.
